vdf_sqr_ctrl: RTL
=================

VDF_SQR_CTRL -- requirements
Module: vdf_sqr_ctrl

Interface
REQ-001 Parameter BITS, default 1024: operand and result width; it matches the downstream modular multiplier.
REQ-002 Parameter CNT_W, default 32: iteration-count width.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles in WAIT before abort.
REQ-004 i_clk  in  1  single clock; all logic rising-edge.
REQ-005 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 i_start_val  in  1  job request valid.
REQ-007 o_start_rdy  out  1  job can be accepted.
REQ-008 i_start_dat  in  BITS  initial value x0.
REQ-009 i_start_cnt  in  CNT_W  number of squarings T.
REQ-010 o_mul_val  out  1  square request to the multiplier.
REQ-011 i_mul_rdy  in  1  multiplier accepts the request.
REQ-012 o_mul_dat_a, o_mul_dat_b  out  BITS each  both equal the current x.
REQ-013 i_mul_val  in  1  multiplier result valid.
REQ-014 i_mul_dat  in  BITS  x^2 mod N.
REQ-015 o_mul_rdy  out  1  constant 1; one request is in flight at most, so the controller never stalls the multiplier.
REQ-016 o_res_val  out  1  final result valid.
REQ-017 i_res_rdy  in  1  consumer accepts the result.
REQ-018 o_res_dat  out  BITS  x_T.
REQ-019 o_res_err  out  1  job aborted by timeout; qualified by o_res_val.
REQ-020 o_remain  out  CNT_W  squarings still outstanding, for progress monitoring.

Function
REQ-021 The state machine SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: o_start_rdy=1; on i_start_val, latch x<=i_start_dat and o_remain<=i_start_cnt; next state is DONE if i_start_cnt==0, otherwise ISSUE.
REQ-023 ISSUE: o_mul_val=1 with operands equal to x; on i_mul_rdy go to WAIT (the handshake completes that cycle); operands SHALL stay stable while i_mul_rdy=0.
REQ-024 WAIT: on i_mul_val, x<=i_mul_dat and o_remain decrements by 1; next state is DONE if the decremented value is 0, otherwise ISSUE.
REQ-025 Issue rate: the next o_mul_val SHALL assert the cycle after i_mul_val, giving a period of multiplier latency + 1 cycles per squaring.
REQ-026 WAIT watchdog: the counter clears on WAIT entry and increments each WAIT cycle; reaching TIMEOUT with no i_mul_val gives o_res_err<=1 and a move to DONE, with x and o_remain frozen.
REQ-027 DONE: o_res_val=1, o_res_dat=x, o_res_err held; all three stay stable until i_res_rdy; on i_res_rdy go to IDLE and clear o_res_err.
REQ-028 If i_mul_val and the watchdog expiry occur in the same cycle, the result is accepted and there is no error.
REQ-029 i_mul_val outside WAIT is ignored; state and x are unchanged.
REQ-030 o_start_rdy=0 in every state except IDLE; i_start_val is ignored there.
REQ-031 T=0 returns x0 unchanged, with o_res_val asserted the cycle after the start is accepted.
REQ-032 o_remain does not wrap; T=2^CNT_W-1 is legal.

Reset
REQ-033 While i_rst_n=0: state is IDLE; o_mul_val, o_res_val and o_res_err are 0; o_remain, x and the watchdog counter are 0; o_start_rdy=1 after release.
REQ-034 Reset mid-job abandons the job; a late i_mul_val after release is ignored per REQ-029.

Structure
REQ-035 The state enum typedef and the default widths SHALL live in the shared package vdf_pkg.
REQ-036 The block is a single module; the watchdog is an inline counter, not a sub-module.
REQ-037 Target size is 120-400 lines of RTL; the module instantiates no DSP or RAM.

Verification
The bench multiplier model is x^2 mod 251 with a latency of 5 cycles.
REQ-038 Basic: x0=3, T=3 -> o_res_dat=35 (3→9→81→35); o_res_val asserts 3×6 cycles after the first issue; o_res_err=0.
REQ-039 T=0: x0=200 -> o_res_dat=200 one cycle after acceptance, with no o_mul_val pulse.
REQ-040 Backpressure: hold i_mul_rdy=0 for 4 cycles in ISSUE and i_res_rdy=0 for 10 cycles in DONE -> operands and result are stable; final value matches REQ-038.
REQ-041 Timeout: TIMEOUT=8 and the model never answers -> o_res_err=1 and o_remain=T at o_res_val, 8 cycles after WAIT entry; the next job runs cleanly.
REQ-042 Reset: assert i_rst_n=0 in WAIT of the second squaring, then the model emits a stale i_mul_val -> state stays IDLE; a new job x0=2, T=2 returns 16.
REQ-043 Boundary: i_mul_val arrives exactly at watchdog expiry -> result accepted and o_res_err=0.

Source files
------------

// File: rtl/vdf_pkg.sv
// rtl/vdf_pkg.sv - shared state type and default widths for the VDF squaring controller
package vdf_pkg;

  localparam int VDF_BITS    = 1024;
  localparam int VDF_CNT_W   = 32;
  localparam int VDF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } vdf_state_t;

endpackage

// File: rtl/vdf_sqr_ctrl.sv
// rtl/vdf_sqr_ctrl.sv - sequential squaring controller driving an external modular multiplier
module vdf_sqr_ctrl
  import vdf_pkg::*;
#(
  parameter int BITS    = VDF_BITS,
  parameter int CNT_W   = VDF_CNT_W,
  parameter int TIMEOUT = VDF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_val,
  output logic             o_start_rdy,
  input  logic [BITS-1:0]  i_start_dat,
  input  logic [CNT_W-1:0] i_start_cnt,
  output logic             o_mul_val,
  input  logic             i_mul_rdy,
  output logic [BITS-1:0]  o_mul_dat_a,
  output logic [BITS-1:0]  o_mul_dat_b,
  input  logic             i_mul_val,
  input  logic [BITS-1:0]  i_mul_dat,
  output logic             o_mul_rdy,
  output logic             o_res_val,
  input  logic             i_res_rdy,
  output logic [BITS-1:0]  o_res_dat,
  output logic             o_res_err,
  output logic [CNT_W-1:0] o_remain
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  vdf_state_t      state;
  logic [BITS-1:0] x;
  logic [WD_W-1:0] wd_cnt;

  // Only one square is ever in flight, so results are always accepted.
  assign o_mul_rdy   = 1'b1;
  assign o_mul_dat_a = x;
  assign o_mul_dat_b = x;
  assign o_res_dat   = x;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      x           <= '0;
      o_remain    <= '0;
      wd_cnt      <= '0;
      o_start_rdy <= 1'b1;
      o_mul_val   <= 1'b0;
      o_res_val   <= 1'b0;
      o_res_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start_val) begin
            x           <= i_start_dat;
            o_remain    <= i_start_cnt;
            o_start_rdy <= 1'b0;
            if (i_start_cnt == '0) begin
              state     <= ST_DONE;
              o_res_val <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              o_mul_val <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (i_mul_rdy) begin
            state     <= ST_WAIT;
            o_mul_val <= 1'b0;
            wd_cnt    <= '0;
          end
        end
        ST_WAIT: begin
          // A result landing on the expiry cycle wins over the watchdog.
          if (i_mul_val) begin
            x        <= i_mul_dat;
            o_remain <= o_remain - CNT_ONE;
            if (o_remain == CNT_ONE) begin
              state     <= ST_DONE;
              o_res_val <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              o_mul_val <= 1'b1;
            end
          end else if (wd_cnt == WD_LAST) begin
            state     <= ST_DONE;
            o_res_val <= 1'b1;
            o_res_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end
        ST_DONE: begin
          if (i_res_rdy) begin
            state       <= ST_IDLE;
            o_res_val   <= 1'b0;
            o_res_err   <= 1'b0;
            o_start_rdy <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
